// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM state encoding and default identification bytes
// for the SPI NOR flash responder.
package spi_flash_pkg;

    localparam logic [7:0]  OP_READ = 8'h03;
    localparam logic [7:0]  OP_RDID = 8'h9F;
    localparam logic [7:0]  OP_RDSR = 8'h05;

    localparam logic [23:0] DEFAULT_JEDEC_ID = 24'hEF4018;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_ID,
        ST_STAT,
        ST_IGNORE
    } state_t;

    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd2:    id_byte = id[23:16];
            2'd1:    id_byte = id[15:8];
            default: id_byte = id[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_responder_spi_in_sync.sv
// Brings SCK, SS_N and MOSI into the CLOCK domain and flags SCK edges
// from the last two synchronized SCK samples.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic spi_sck,
    input  logic spi_ss_n,
    input  logic spi_mosi,
    output logic sck_rise,
    output logic sck_fall,
    output logic ss_active,
    output logic mosi_s
);

    localparam int MSB = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sck_d;

    // SS_N resets to deselected so busy is low straight out of reset
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_sync[MSB];
        end
    end

    assign sck_rise  = sck_sync[MSB] & ~sck_d;
    assign sck_fall  = ~sck_sync[MSB] & sck_d;
    assign ss_active = ~ss_sync[MSB];
    assign mosi_s    = mosi_sync[MSB];

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 slave emulating a serial NOR flash (READ, READ-ID, READ-STATUS),
// fetching read data byte by byte from a parallel request/ack port.
//
// state     | meaning
// ----------+--------------------------------------------------------
// ST_IDLE   | deselected, waiting for SS_N to fall
// ST_CMD    | shifting in the 8-bit opcode
// ST_ADDR   | shifting in the 24-bit read address
// ST_DATA   | streaming fetched bytes, one-entry prefetch
// ST_ID     | streaming JEDEC_ID bytes 2,1,0 then byte 0 repeatedly
// ST_STAT   | streaming status 0x00
// ST_IGNORE | unknown opcode, MISO released, no fetches
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W      = 24,
    parameter logic [23:0] JEDEC_ID    = DEFAULT_JEDEC_ID,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              spi_sck,
    input  logic              spi_ss_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              underrun
);

    logic sck_rise, sck_fall, ss_active, mosi_s;

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .spi_sck   (spi_sck),
        .spi_ss_n  (spi_ss_n),
        .spi_mosi  (spi_mosi),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .ss_active (ss_active),
        .mosi_s    (mosi_s)
    );

    state_t            state;
    logic [4:0]        bit_cnt;
    logic [ADDR_W-1:0] shift_in;
    logic [7:0]        shift_out;
    logic [7:0]        pf_data;
    logic              pf_valid;
    logic              fetch_due;
    logic              discard;
    logic              ss_prev;
    logic [1:0]        id_idx;

    logic              ack_ok, ack_use, boundary;
    logic [ADDR_W-1:0] rx_word;
    logic [7:0]        id_cur;

    assign ack_ok   = mem_ack & mem_req;
    assign ack_use  = ack_ok & ~discard & ss_active & (state == ST_DATA);
    assign boundary = sck_fall & (bit_cnt[2:0] == 3'd0);
    assign rx_word  = {shift_in[ADDR_W-2:0], mosi_s};
    assign id_cur   = id_byte(JEDEC_ID, id_idx);
    assign busy     = ss_active;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift_in    <= '0;
            shift_out   <= '0;
            pf_data     <= '0;
            pf_valid    <= 1'b0;
            fetch_due   <= 1'b0;
            discard     <= 1'b0;
            ss_prev     <= 1'b0;
            id_idx      <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            underrun    <= 1'b0;
        end else begin
            ss_prev <= ss_active;
            if (ack_ok) begin
                mem_req <= 1'b0;
                discard <= 1'b0;
            end
            if (ack_use) begin
                pf_data  <= mem_data;
                pf_valid <= 1'b1;
            end
            // first fetch held back by a leftover request from an aborted transfer
            if (fetch_due && !mem_req && ss_active && state == ST_DATA) begin
                mem_addr  <= shift_in;
                mem_req   <= 1'b1;
                fetch_due <= 1'b0;
            end
            if (!ss_active) begin
                state       <= ST_IDLE;
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
                pf_valid    <= 1'b0;
                fetch_due   <= 1'b0;
                if (mem_req && !mem_ack) discard <= 1'b1;
            end else begin
                if (state inside {ST_DATA, ST_ID, ST_STAT}) begin
                    if (sck_rise) bit_cnt <= bit_cnt + 5'd1;
                    if (sck_fall && !boundary) begin
                        spi_miso  <= shift_out[7];
                        shift_out <= {shift_out[6:0], 1'b0};
                    end
                end
                case (state)
                    ST_IDLE: begin
                        if (!ss_prev) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sck_rise) begin
                            shift_in <= rx_word;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                case (rx_word[7:0])
                                    OP_READ: state <= ST_ADDR;
                                    OP_RDID: begin
                                        state       <= ST_ID;
                                        id_idx      <= 2'd2;
                                        spi_miso_oe <= 1'b1;
                                    end
                                    OP_RDSR: begin
                                        state       <= ST_STAT;
                                        spi_miso_oe <= 1'b1;
                                    end
                                    default: state <= ST_IGNORE;
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sck_rise) begin
                            shift_in <= rx_word;
                            if (bit_cnt == 5'd23) begin
                                bit_cnt     <= '0;
                                state       <= ST_DATA;
                                spi_miso_oe <= 1'b1;
                                if (mem_req) begin
                                    fetch_due <= 1'b1;
                                end else begin
                                    mem_addr <= rx_word;
                                    mem_req  <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 5'd1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (boundary) begin
                            if (pf_valid) begin
                                spi_miso  <= pf_data[7];
                                shift_out <= {pf_data[6:0], 1'b0};
                                pf_valid  <= 1'b0;
                                mem_addr  <= mem_addr + 1'b1;
                                mem_req   <= 1'b1;
                            end else if (ack_use) begin
                                spi_miso  <= mem_data[7];
                                shift_out <= {mem_data[6:0], 1'b0};
                                pf_valid  <= 1'b0;
                                mem_addr  <= mem_addr + 1'b1;
                                mem_req   <= 1'b1;
                            end else begin
                                spi_miso  <= 1'b1;
                                shift_out <= 8'hFE;
                                underrun  <= 1'b1;
                            end
                        end
                    end
                    ST_ID: begin
                        if (boundary) begin
                            spi_miso  <= id_cur[7];
                            shift_out <= {id_cur[6:0], 1'b0};
                            if (id_idx != 2'd0) id_idx <= id_idx - 2'd1;
                        end
                    end
                    ST_STAT: begin
                        if (boundary) begin
                            spi_miso  <= 1'b0;
                            shift_out <= 8'h00;
                        end
                    end
                    ST_IGNORE: ;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: a mode-0 SPI master at CLOCK/8 and
// a byte-fetch memory that returns addr[7:0] after a programmable delay.
module tb_spi_flash_responder;
    import spi_flash_pkg::*;

    localparam int H = 4;

    logic        CLOCK, RESET;
    logic        spi_sck, spi_ss_n, spi_mosi;
    logic        spi_miso, spi_miso_oe;
    logic        mem_req, mem_ack;
    logic [23:0] mem_addr;
    logic [7:0]  mem_data;
    logic        busy, underrun;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ack_delay = 2;
    int          wait_cnt = 0;
    bit          ack_en = 1'b1;
    bit          req_seen = 1'b0;
    bit          oe_any = 1'b0;
    int          n_req = 0;
    logic [23:0] req_log [0:15];
    logic [7:0]  rx;
    int          fall_cyc;

    spi_flash_responder dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .spi_sck     (spi_sck),
        .spi_ss_n    (spi_ss_n),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .busy        (busy),
        .underrun    (underrun)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // memory side: ack once per request after ack_delay idle negedges
    initial begin
        mem_ack  = 1'b0;
        mem_data = 8'h00;
        forever begin
            @(negedge CLOCK);
            if (mem_req) req_seen = 1'b1;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end else if (mem_req && ack_en) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_addr[7:0];
                    if (n_req < 16) req_log[n_req[3:0]] = mem_addr;
                    n_req++;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_txn();
        spi_sck  = 1'b0;
        spi_ss_n = 1'b0;
        oe_any   = 1'b0;
        repeat (4) @(negedge CLOCK);
    endtask

    // final SCK fall coincides with SS_N rise when end_txn is set
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit end_txn,
                            output logic [7:0] rxd);
        logic [7:0] sh;
        sh  = tx;
        rxd = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = sh[7];
            sh       = {sh[6:0], 1'b0};
            repeat (H) @(negedge CLOCK);
            spi_sck = 1'b1;
            rxd     = {rxd[6:0], spi_miso};
            if (spi_miso_oe) oe_any = 1'b1;
            repeat (H) @(negedge CLOCK);
            spi_sck = 1'b0;
            if (end_txn && i == nbits - 1) spi_ss_n = 1'b1;
        end
        if (end_txn) repeat (8) @(negedge CLOCK);
    endtask

    task automatic send_read(input logic [23:0] addr);
        logic [7:0] d;
        spi_bits(OP_READ, 8, 1'b0, d);
        spi_bits(addr[23:16], 8, 1'b0, d);
        spi_bits(addr[15:8], 8, 1'b0, d);
        spi_bits(addr[7:0], 8, 1'b0, d);
    endtask

    logic [7:0] exp_id [0:3];
    logic [7:0] exp_t1 [0:3];
    logic [7:0] exp_t3 [0:2];

    initial begin
        exp_id = '{8'hEF, 8'h40, 8'h18, 8'h18};
        exp_t1 = '{8'h10, 8'h11, 8'h12, 8'h13};
        exp_t3 = '{8'hFE, 8'hFF, 8'h00};
        RESET    = 1'b1;
        spi_sck  = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (4) @(negedge CLOCK);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_oe", 32'(spi_miso_oe), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        RESET = 1'b0;
        repeat (4) @(negedge CLOCK);

        // 1: READ at 0x000010, 4 bytes
        ack_delay = 2;
        n_req = 0;
        start_txn();
        check("t1_busy", 32'(busy), 32'd1);
        send_read(24'h000010);
        for (int k = 0; k < 4; k++) begin
            spi_bits(8'h00, 8, k == 3, rx);
            check("t1_byte", 32'(rx), 32'(exp_t1[k]));
        end
        check("t1_underrun", 32'(underrun), 32'd0);
        check("t1_addr_end", 32'(mem_addr), 32'h000014);
        check("t1_nreq", 32'(n_req), 32'd5);
        check("t1_busy_end", 32'(busy), 32'd0);

        // 2: READ-ID with 4 dummy bytes
        req_seen = 1'b0;
        start_txn();
        spi_bits(OP_RDID, 8, 1'b0, rx);
        for (int k = 0; k < 4; k++) begin
            spi_bits(8'h00, 8, k == 3, rx);
            check("t2_id", 32'(rx), 32'(exp_id[k]));
        end
        check("t2_no_req", 32'(req_seen), 32'd0);

        // 3: READ wrapping past the top of the address space
        n_req = 0;
        start_txn();
        send_read(24'hFFFFFE);
        for (int k = 0; k < 3; k++) begin
            spi_bits(8'h00, 8, k == 2, rx);
            check("t3_byte", 32'(rx), 32'(exp_t3[k]));
        end
        check("t3_fetch0", 32'(req_log[0]), 32'h00FFFFFE);
        check("t3_fetch1", 32'(req_log[1]), 32'h00FFFFFF);
        check("t3_fetch2", 32'(req_log[2]), 32'h00000000);

        // 4: slow memory, first byte underruns
        ack_delay = 40;
        start_txn();
        send_read(24'h000020);
        spi_bits(8'h00, 8, 1'b0, rx);
        check("t4_byte0", 32'(rx), 32'h000000FF);
        check("t4_underrun_mid", 32'(underrun), 32'd1);
        spi_bits(8'h00, 8, 1'b1, rx);
        check("t4_byte1", 32'(rx), 32'h00000020);
        check("t4_underrun_sticky", 32'(underrun), 32'd1);

        // 5: abort after 12 address bits, then READ-STATUS
        ack_delay = 2;
        req_seen = 1'b0;
        start_txn();
        spi_bits(OP_READ, 8, 1'b0, rx);
        spi_bits(8'h12, 8, 1'b0, rx);
        spi_bits(8'h34, 4, 1'b0, rx);
        spi_ss_n = 1'b1;
        fall_cyc = 99;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLOCK);
            if (!busy) begin
                fall_cyc = c;
                break;
            end
        end
        check("t5_busy_fall", 32'(fall_cyc <= 3), 32'd1);
        repeat (8) @(negedge CLOCK);
        check("t5_no_req_abort", 32'(req_seen), 32'd0);
        start_txn();
        spi_bits(OP_RDSR, 8, 1'b0, rx);
        for (int k = 0; k < 2; k++) begin
            spi_bits(8'h00, 8, k == 1, rx);
            check("t5_status", 32'(rx), 32'd0);
        end
        check("t5_oe_seen", 32'(oe_any), 32'd1);
        check("t5_no_req", 32'(req_seen), 32'd0);

        // 6: RESET in DATA with a request outstanding
        ack_en = 1'b0;
        start_txn();
        send_read(24'h000040);
        spi_bits(8'h00, 3, 1'b0, rx);
        check("t6_req_before", 32'(mem_req), 32'd1);
        check("t6_underrun_before", 32'(underrun), 32'd1);
        RESET = 1'b1;
        @(negedge CLOCK);
        check("t6_req", 32'(mem_req), 32'd0);
        check("t6_oe", 32'(spi_miso_oe), 32'd0);
        check("t6_underrun", 32'(underrun), 32'd0);
        check("t6_state", 32'(dut.state), 32'(ST_IDLE));
        spi_ss_n = 1'b1;
        spi_sck  = 1'b0;
        repeat (2) @(negedge CLOCK);
        RESET  = 1'b0;
        ack_en = 1'b1;
        repeat (4) @(negedge CLOCK);
        req_seen = 1'b0;
        start_txn();
        spi_bits(8'h5A, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b0, rx);
        spi_bits(8'h00, 8, 1'b1, rx);
        check("t6_ignore_oe", 32'(oe_any), 32'd0);
        check("t6_ignore_req", 32'(req_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
